// File: rtl/dspuva_pkg.sv
// Shared definitions for the DSPuva MAC coprocessor: opcode encodings and FSM states.
package dspuva_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MAC = 2'b01;
  localparam logic [1:0] OP_MSU = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/dspuva_mac_sat.sv
// Combinational round-half-up, arithmetic shift by SH, then clamp (or wrap) IW bits down to OW bits.
module dspuva_mac_sat #(
  parameter int IW = 41,
  parameter int OW = 40,
  parameter int SH = 0
) (
  input  logic [IW-1:0] din,
  input  logic          sat_en,
  output logic [OW-1:0] dout
);

  localparam int RW = IW + 1;
  // Half an LSB of the shifted result; collapses to zero when SH is zero.
  localparam logic [RW-1:0] RND = (RW'(1) << SH) >> 1;

  logic signed [RW-1:0] rnd_sum;
  logic signed [RW-1:0] shifted;
  logic                 fits;

  always_comb begin
    rnd_sum = $signed({din[IW-1], din}) + $signed(RND);
    shifted = rnd_sum >>> SH;
    fits    = (&shifted[RW-1:OW-1]) | ~(|shifted[RW-1:OW-1]);
    if (fits || !sat_en) begin
      dout = shifted[OW-1:0];
    end else if (shifted[RW-1]) begin
      dout = {1'b1, {(OW-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/dspuva_mac.sv
// Digit-serial signed multiply-accumulate engine with MUL/MAC/MSU/CLR, optional saturation
// and a rounded Q-format DOUT view of the accumulator.
module dspuva_mac
  import dspuva_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 40,
  parameter int NIB  = 4,
  parameter int FRAC = DW - 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [1:0]    OP,
  input  logic          SAT,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [AW-1:0] ACC_OUT,
  output logic [DW-1:0] DOUT,
  output logic          OVF,
  output state_t        DBG_STATE
);

  localparam int K  = DW / NIB;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * DW;

  state_t        state, state_nxt;
  logic [DW-1:0] a_q, b_q;
  logic [1:0]    op_q;
  logic          sat_q;
  logic [PW-1:0] pp;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc_q, acc_nxt;
  logic [DW-1:0] dout_q, dout_nxt;
  logic          ovf_q;

  logic [NIB-1:0] digit;
  logic [PW-1:0]  digit_x, b_x, term;
  logic [AW:0]    p_x, acc_x, sum;
  logic           sum_ovf;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // requests are only taken in IDLE and results are held in OUT until OUT_READY.
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_nxt = (OP == OP_CLR) ? S_ACC : S_MUL;
      end
      S_MUL:   if (cnt == CW'(K - 1)) state_nxt = S_ACC;
      S_ACC:   state_nxt = S_OUT;
      S_OUT: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The top digit of A is taken as signed so the serial product is exact for negative A.
  always_comb begin
    digit   = a_q[cnt*NIB +: NIB];
    digit_x = (cnt == CW'(K - 1)) ? {{(PW-NIB){digit[NIB-1]}}, digit}
                                  : {{(PW-NIB){1'b0}}, digit};
    b_x     = {{DW{b_q[DW-1]}}, b_q};
    term    = (b_x * digit_x) << (cnt * NIB);
  end

  always_comb begin
    p_x   = {{(AW+1-PW){pp[PW-1]}}, pp};
    acc_x = {acc_q[AW-1], acc_q};
    case (op_q)
      OP_MUL:  sum = p_x;
      OP_MAC:  sum = acc_x + p_x;
      OP_MSU:  sum = acc_x - p_x;
      default: sum = '0;
    endcase
    sum_ovf = sum[AW] ^ sum[AW-1];
  end

  dspuva_mac_sat #(.IW(AW + 1), .OW(AW), .SH(0)) u_acc_sat (
    .din    (sum),
    .sat_en (sat_q),
    .dout   (acc_nxt)
  );

  dspuva_mac_sat #(.IW(AW), .OW(DW), .SH(FRAC)) u_dout_sat (
    .din    (acc_nxt),
    .sat_en (1'b1),
    .dout   (dout_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_MUL;
      sat_q  <= 1'b0;
      pp     <= '0;
      cnt    <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= OP;
            sat_q <= SAT;
            pp    <= '0;
            cnt   <= '0;
          end
        end
        S_MUL: begin
          pp  <= pp + term;
          cnt <= cnt + 1'b1;
        end
        S_ACC: begin
          acc_q  <= acc_nxt;
          dout_q <= dout_nxt;
          ovf_q  <= (op_q == OP_CLR) ? 1'b0 : (ovf_q | sum_ovf);
        end
        default: ;
      endcase
    end
  end

  assign ACC_OUT   = acc_q;
  assign DOUT      = dout_q;
  assign OVF       = ovf_q;
  assign DBG_STATE = state;

endmodule
